// File: rtl/adsr_multi.sv
// ---------------------------------------------------------------------------
// adsr_multi -- multi-channel ADSR envelope generator.
//
// Each channel runs its own IDLE/ATTACK/DECAY/SUSTAIN/RELEASE state machine
// on a signed-range accumulator (full scale FS = 2^(ACC_W-1)-1). All channels
// advance in parallel on every rising clock edge. Envelope samples are the top
// ENV_W magnitude bits of each accumulator, so FS maps to all-ones.
//
// Parameters:
//   CHANNELS  number of independent envelope channels
//   ACC_W     accumulator width
//   ENV_W     output sample width per channel
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous reset, active HIGH (legacy name)
//   i_trig       per-channel one-cycle start / retrigger pulse
//   i_gate       per-channel gate level (only used by channels in gate mode)
//   i_cfg_we     configuration write strobe
//   i_cfg_ch     configuration target channel
//   i_cfg_sel    register select: 0 attack_step, 1 decay_step,
//                2 sustain_level, 3 release_step, 4 sustain_time,
//                5 mode (bit0: 1=gate, 0=timed); 6-7 ignored
//   i_cfg_data   configuration write data
//   o_env        envelopes, channel n at [n*ENV_W +: ENV_W]
//   o_active     channel state is not IDLE
//   o_done       (ADSR_DONE_PULSE_EN only) one-cycle pulse when a channel
//                has just finished RELEASE and returned to IDLE
//   o_dbg_state  per-channel FSM state, channel n at [n*3 +: 3]
//
// Optional feature macro: ADSR_DONE_PULSE_EN adds o_done and its logic.
//
// Configuration interface: there is no handshake. A write is accepted on
// every rising edge where i_cfg_we is high (and reset is low); the new value
// is visible to the channel logic from the following cycle onward.
// ---------------------------------------------------------------------------
module adsr_multi #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 32,
  parameter int ENV_W    = 16
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic [CHANNELS-1:0]                           i_trig,
  input  logic [CHANNELS-1:0]                           i_gate,
  input  logic                                          i_cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] i_cfg_ch,
  input  logic [2:0]                                    i_cfg_sel,
  input  logic [ACC_W-1:0]                              i_cfg_data,
  output logic [CHANNELS*ENV_W-1:0]                     o_env,
  output logic [CHANNELS-1:0]                           o_active,
`ifdef ADSR_DONE_PULSE_EN
  output logic [CHANNELS-1:0]                           o_done,
`endif
  output logic [CHANNELS*3-1:0]                         o_dbg_state
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [ACC_W-1:0] FS = {1'b0, {(ACC_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    // Configuration registers
    logic [ACC_W-1:0] r_attack;
    logic [ACC_W-1:0] r_decay;
    logic [ACC_W-1:0] r_sustain;
    logic [ACC_W-1:0] r_release;
    logic [ACC_W-1:0] r_stime;
    logic             r_mode_cfg;

    // Channel state
    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_cnt;
    logic             r_mode;    // mode latched when leaving IDLE
    logic             r_gate_q;  // previous gate level for edge detect

    logic [ACC_W-1:0] w_sus;
    logic [ACC_W:0]   w_att_sum;
    logic [ACC_W:0]   w_dec_diff;
    logic [ACC_W:0]   w_rel_diff;
    logic             w_cfg_hit;
    logic             w_gate_rise;
    logic             w_gate_drop;
    logic             w_att_done;
    logic             w_dec_done;
    logic             w_rel_done;

    assign w_cfg_hit   = i_cfg_we && (i_cfg_ch == CH_W'(n));
    // A sustain level above full scale behaves as full scale.
    assign w_sus       = (r_sustain > FS) ? FS : r_sustain;
    // One extra bit on every add/subtract so overflow and underflow are
    // detected instead of wrapping.
    assign w_att_sum   = {1'b0, r_acc} + {1'b0, r_attack};
    assign w_dec_diff  = {1'b0, r_acc} - {1'b0, r_decay};
    assign w_rel_diff  = {1'b0, r_acc} - {1'b0, r_release};
    assign w_att_done  = (w_att_sum >= {1'b0, FS});
    assign w_dec_done  = w_dec_diff[ACC_W] || (w_dec_diff[ACC_W-1:0] <= w_sus);
    assign w_rel_done  = w_rel_diff[ACC_W] || (w_rel_diff[ACC_W-1:0] == '0);
    assign w_gate_rise = i_gate[n] && !r_gate_q;
    // Gate released while the note is still sounding (gate mode only).
    assign w_gate_drop = r_mode && !i_gate[n] &&
                         ((r_state == S_ATTACK) || (r_state == S_DECAY) ||
                          (r_state == S_SUSTAIN));

    always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
        r_attack   <= '0;
        r_decay    <= '0;
        r_sustain  <= '0;
        r_release  <= '0;
        r_stime    <= '0;
        r_mode_cfg <= 1'b0;
      end else if (w_cfg_hit) begin
        case (i_cfg_sel)
          3'd0:    r_attack   <= i_cfg_data;
          3'd1:    r_decay    <= i_cfg_data;
          3'd2:    r_sustain  <= i_cfg_data;
          3'd3:    r_release  <= i_cfg_data;
          3'd4:    r_stime    <= i_cfg_data;
          3'd5:    r_mode_cfg <= i_cfg_data[0];
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
        r_state  <= S_IDLE;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_mode   <= 1'b0;
        r_gate_q <= 1'b0;
      end else begin
        r_gate_q <= i_gate[n];
        if ((r_state != S_IDLE) && i_trig[n]) begin
          // Retrigger restarts the attack from the current level.
          r_state <= S_ATTACK;
        end else if (w_gate_drop) begin
          r_state <= S_RELEASE;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (i_trig[n] || (r_mode_cfg && w_gate_rise)) begin
                r_state <= S_ATTACK;
                r_mode  <= r_mode_cfg;
              end
            end
            S_ATTACK: begin
              if (w_att_done) begin
                r_acc   <= FS;
                r_state <= S_DECAY;
              end else begin
                r_acc <= w_att_sum[ACC_W-1:0];
              end
            end
            S_DECAY: begin
              if (w_dec_done) begin
                r_acc   <= w_sus;
                r_state <= S_SUSTAIN;
                r_cnt   <= r_mode ? '0 : r_stime;
              end else begin
                r_acc <= w_dec_diff[ACC_W-1:0];
              end
            end
            S_SUSTAIN: begin
              r_acc <= w_sus;
              // A counter of 0 still spends one cycle here before release.
              if (!r_mode) begin
                if (r_cnt == '0) r_state <= S_RELEASE;
                else             r_cnt   <= r_cnt - ACC_W'(1);
              end
            end
            S_RELEASE: begin
              if (w_rel_done) begin
                r_acc   <= '0;
                r_state <= S_IDLE;
              end else begin
                r_acc <= w_rel_diff[ACC_W-1:0];
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end

`ifdef ADSR_DONE_PULSE_EN
    logic r_done;
    logic w_to_idle;

    assign w_to_idle = (r_state == S_RELEASE) && !i_trig[n] && w_rel_done;

    always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) r_done <= 1'b0;
      else         r_done <= w_to_idle;
    end

    assign o_done[n] = r_done;
`endif

    assign o_env[n*ENV_W +: ENV_W] = r_acc[ACC_W-2 -: ENV_W];
    assign o_active[n]             = (r_state != S_IDLE);
    assign o_dbg_state[n*3 +: 3]   = r_state;
  end

endmodule

// File: tb/tb_adsr_multi.sv
// ---------------------------------------------------------------------------
// tb_adsr_multi -- directed self-checking bench for adsr_multi.
// Expected envelope values are hand-computed from FS = 0x7FFFFFFF and the
// step sizes below; o_env is acc[30:15].
// ---------------------------------------------------------------------------
module tb_adsr_multi;
  localparam int CHANNELS = 4;
  localparam int ACC_W    = 32;
  localparam int ENV_W    = 16;

  localparam logic [31:0] FS  = 32'h7FFF_FFFF;
  localparam logic [31:0] ATT = 32'd21474836;   // FS/100
  localparam logic [31:0] DEC = 32'd10737418;   // (FS-FS/2)/100
  localparam logic [31:0] SUS = 32'd1073741823; // FS/2
  localparam logic [31:0] REL = 32'd10737418;   // (FS/2)/100

  // clock / reset
  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [CHANNELS-1:0]       i_trig;
  logic [CHANNELS-1:0]       i_gate;
  logic                      i_cfg_we;
  logic [1:0]                i_cfg_ch;
  logic [2:0]                i_cfg_sel;
  logic [ACC_W-1:0]          i_cfg_data;
  logic [CHANNELS*ENV_W-1:0] o_env;
  logic [CHANNELS-1:0]       o_active;
  logic [CHANNELS*3-1:0]     o_dbg_state;
`ifdef ADSR_DONE_PULSE_EN
  logic [CHANNELS-1:0]       o_done;
  int                        done_cnt = 0;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  adsr_multi #(.CHANNELS(CHANNELS), .ACC_W(ACC_W), .ENV_W(ENV_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_trig      (i_trig),
    .i_gate      (i_gate),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_ch    (i_cfg_ch),
    .i_cfg_sel   (i_cfg_sel),
    .i_cfg_data  (i_cfg_data),
    .o_env       (o_env),
    .o_active    (o_active),
`ifdef ADSR_DONE_PULSE_EN
    .o_done      (o_done),
`endif
    .o_dbg_state (o_dbg_state)
  );

`ifdef ADSR_DONE_PULSE_EN
  always @(negedge clk) if (o_done[0] === 1'b1) done_cnt++;
`endif

  function automatic logic [15:0] env_of(input int ch);
    return o_env[ch*ENV_W +: ENV_W];
  endfunction

  function automatic logic [2:0] st_of(input int ch);
    return o_dbg_state[ch*3 +: 3];
  endfunction

  // driver tasks: always called at a negedge, return at a negedge
  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_trig(input int ch);
    i_trig[ch] = 1'b1;
    @(negedge clk);
    i_trig[ch] = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input logic [2:0] sel, input logic [31:0] data);
    i_cfg_we   = 1'b1;
    i_cfg_ch   = ch[1:0];
    i_cfg_sel  = sel;
    i_cfg_data = data;
    @(negedge clk);
    i_cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    wait_cyc(3);
    total++; if (o_env !== '0) $display("FAIL reset_env: got %h want 0", o_env); else passed++;
    total++; if (o_active !== 4'b0) $display("FAIL reset_active: got %b want 0000", o_active); else passed++;
    reset_n = 1'b0;
    wait_cyc(2);
    total++; if (o_dbg_state !== '0) $display("FAIL post_reset_state: got %h want 0", o_dbg_state); else passed++;
  endtask

  task automatic test_config();
    for (int ch = 0; ch < 3; ch++) begin
      cfg_write(ch, 3'd0, ATT);
      cfg_write(ch, 3'd1, DEC);
      cfg_write(ch, 3'd2, SUS);
      cfg_write(ch, 3'd3, REL);
      cfg_write(ch, 3'd4, 32'd500);
    end
    cfg_write(1, 3'd5, 32'd1);
    cfg_write(2, 3'd5, 32'd1);
    cfg_write(3, 3'd0, FS);
    cfg_write(3, 3'd1, FS);
    cfg_write(3, 3'd2, 32'hFFFF_FFFF);
    cfg_write(3, 3'd3, FS);
    total++; if (o_active !== 4'b0) $display("FAIL cfg_no_start: got %b want 0000", o_active); else passed++;
  endtask

  task automatic test_timed();
    pulse_trig(0);  // E0
    total++; if (o_active[0] !== 1'b1) $display("FAIL timed_e0_active: got %b want 1", o_active[0]); else passed++;
    total++; if (env_of(0) !== 16'h0000) $display("FAIL timed_e0_env: got %h want 0000", env_of(0)); else passed++;
    wait_cyc(1);    // E1
    total++; if (env_of(0) !== 16'd655) $display("FAIL timed_e1_env: got %0d want 655", env_of(0)); else passed++;
    wait_cyc(100);  // E101
    total++; if (env_of(0) !== 16'hFFFF) $display("FAIL timed_peak_env: got %h want ffff", env_of(0)); else passed++;
    total++; if (st_of(0) !== 3'd2) $display("FAIL timed_peak_state: got %0d want 2", st_of(0)); else passed++;
    wait_cyc(101);  // E202
    total++; if (env_of(0) !== 16'h7FFF) $display("FAIL timed_sus_env: got %h want 7fff", env_of(0)); else passed++;
    total++; if (st_of(0) !== 3'd3) $display("FAIL timed_sus_state: got %0d want 3", st_of(0)); else passed++;
    wait_cyc(500);  // E702
    total++; if (env_of(0) !== 16'h7FFF) $display("FAIL timed_sus_end_env: got %h want 7fff", env_of(0)); else passed++;
    total++; if (st_of(0) !== 3'd3) $display("FAIL timed_sus_end_state: got %0d want 3", st_of(0)); else passed++;
    wait_cyc(2);    // E704
    total++; if (env_of(0) !== 16'd32440) $display("FAIL timed_rel1_env: got %0d want 32440", env_of(0)); else passed++;
    wait_cyc(99);   // E803
    total++; if (o_active[0] !== 1'b1) $display("FAIL timed_rel_last_active: got %b want 1", o_active[0]); else passed++;
    wait_cyc(1);    // E804
    total++; if (o_active[0] !== 1'b0) $display("FAIL timed_idle_active: got %b want 0", o_active[0]); else passed++;
    total++; if (env_of(0) !== 16'h0000) $display("FAIL timed_idle_env: got %h want 0000", env_of(0)); else passed++;
    wait_cyc(3);
`ifdef ADSR_DONE_PULSE_EN
    total++; if (done_cnt !== 1) $display("FAIL done_pulse_count: got %0d want 1", done_cnt); else passed++;
`endif
  endtask

  task automatic test_gate();
    i_gate[1] = 1'b1;
    wait_cyc(1);    // E0
    total++; if (o_active[1] !== 1'b1) $display("FAIL gate_start_active: got %b want 1", o_active[1]); else passed++;
    wait_cyc(1000);
    total++; if (env_of(1) !== 16'h7FFF) $display("FAIL gate_hold_env: got %h want 7fff", env_of(1)); else passed++;
    total++; if (st_of(1) !== 3'd3) $display("FAIL gate_hold_state: got %0d want 3", st_of(1)); else passed++;
    i_gate[1] = 1'b0;
    wait_cyc(1);    // G0
    total++; if (st_of(1) !== 3'd4) $display("FAIL gate_rel_state: got %0d want 4", st_of(1)); else passed++;
    total++; if (env_of(1) !== 16'h7FFF) $display("FAIL gate_rel0_env: got %h want 7fff", env_of(1)); else passed++;
    wait_cyc(1);    // G1
    total++; if (env_of(1) !== 16'd32440) $display("FAIL gate_rel1_env: got %0d want 32440", env_of(1)); else passed++;
    wait_cyc(100);  // G101
    total++; if (o_active[1] !== 1'b0) $display("FAIL gate_idle_active: got %b want 0", o_active[1]); else passed++;
  endtask

  task automatic test_gate_mid_attack();
    i_gate[2] = 1'b1;
    wait_cyc(1);    // E0
    wait_cyc(50);   // E50
    total++; if (env_of(2) !== 16'h7FFF) $display("FAIL mid_attack_env: got %h want 7fff", env_of(2)); else passed++;
    i_gate[2] = 1'b0;
    wait_cyc(1);    // E51
    total++; if (st_of(2) !== 3'd4) $display("FAIL mid_attack_rel_state: got %0d want 4", st_of(2)); else passed++;
    total++; if (env_of(2) !== 16'h7FFF) $display("FAIL mid_attack_rel0_env: got %h want 7fff", env_of(2)); else passed++;
    wait_cyc(1);    // E52
    total++; if (env_of(2) !== 16'd32440) $display("FAIL mid_attack_rel1_env: got %0d want 32440", env_of(2)); else passed++;
    wait_cyc(110);
    total++; if (o_active[2] !== 1'b0) $display("FAIL mid_attack_idle: got %b want 0", o_active[2]); else passed++;
  endtask

  task automatic test_boundary();
    // ch3: full-scale steps, sustain above FS, sustain_time 0
    pulse_trig(3);  // E0
    wait_cyc(1);
    total++; if (st_of(3) !== 3'd2) $display("FAIL bnd_e1_state: got %0d want 2", st_of(3)); else passed++;
    wait_cyc(1);
    total++; if (st_of(3) !== 3'd3) $display("FAIL bnd_e2_state: got %0d want 3", st_of(3)); else passed++;
    total++; if (env_of(3) !== 16'hFFFF) $display("FAIL bnd_e2_env: got %h want ffff", env_of(3)); else passed++;
    wait_cyc(1);
    total++; if (st_of(3) !== 3'd4) $display("FAIL bnd_e3_state: got %0d want 4", st_of(3)); else passed++;
    wait_cyc(1);
    total++; if (o_active[3] !== 1'b0) $display("FAIL bnd_e4_active: got %b want 0", o_active[3]); else passed++;
    total++; if (env_of(3) !== 16'h0000) $display("FAIL bnd_e4_env: got %h want 0000", env_of(3)); else passed++;
  endtask

  task automatic test_retrigger();
    pulse_trig(0);  // E0
    wait_cyc(753);  // E753, release step 50
    total++; if (env_of(0) !== 16'h4000) $display("FAIL retrig_pre_env: got %h want 4000", env_of(0)); else passed++;
    pulse_trig(0);  // T0
    total++; if (st_of(0) !== 3'd1) $display("FAIL retrig_t0_state: got %0d want 1", st_of(0)); else passed++;
    total++; if (env_of(0) !== 16'h4000) $display("FAIL retrig_t0_env: got %h want 4000", env_of(0)); else passed++;
    wait_cyc(1);
    total++; if (env_of(0) !== 16'd17039) $display("FAIL retrig_t1_env: got %0d want 17039", env_of(0)); else passed++;
    wait_cyc(74);   // T75
    total++; if (env_of(0) !== 16'hFFFF) $display("FAIL retrig_t75_env: got %h want ffff", env_of(0)); else passed++;
    total++; if (st_of(0) !== 3'd1) $display("FAIL retrig_t75_state: got %0d want 1", st_of(0)); else passed++;
    wait_cyc(1);
    total++; if (st_of(0) !== 3'd2) $display("FAIL retrig_t76_state: got %0d want 2", st_of(0)); else passed++;
    total++; if (o_active[3:1] !== 3'b000) $display("FAIL retrig_others_active: got %b want 000", o_active[3:1]); else passed++;
    total++; if (o_env[63:16] !== 48'h0) $display("FAIL retrig_others_env: got %h want 0", o_env[63:16]); else passed++;
  endtask

  task automatic test_reset_mid_decay();
    wait_cyc(10);
    total++; if (st_of(0) !== 3'd2) $display("FAIL rst_pre_state: got %0d want 2", st_of(0)); else passed++;
    reset_n = 1'b1;
    #1;
    total++; if (o_env !== '0) $display("FAIL rst_async_env: got %h want 0", o_env); else passed++;
    total++; if (o_active !== 4'b0) $display("FAIL rst_async_active: got %b want 0000", o_active); else passed++;
    // trigger and config write while reset is held must be ignored
    i_trig[1]  = 1'b1;
    i_cfg_we   = 1'b1;
    i_cfg_ch   = 2'd0;
    i_cfg_sel  = 3'd0;
    i_cfg_data = FS;
    wait_cyc(2);
    i_trig[1]  = 1'b0;
    i_cfg_we   = 1'b0;
    reset_n    = 1'b0;
    wait_cyc(2);
    total++; if (o_active !== 4'b0) $display("FAIL rst_trig_ignored: got %b want 0000", o_active); else passed++;
    pulse_trig(0);
    wait_cyc(5);
    total++; if (o_active[0] !== 1'b1) $display("FAIL rst_zero_cfg_active: got %b want 1", o_active[0]); else passed++;
    total++; if (env_of(0) !== 16'h0000) $display("FAIL rst_zero_cfg_env: got %h want 0000", env_of(0)); else passed++;
    total++; if (st_of(0) !== 3'd1) $display("FAIL rst_zero_cfg_state: got %0d want 1", st_of(0)); else passed++;
  endtask

  initial begin
    reset_n    = 1'b1;
    i_trig     = '0;
    i_gate     = '0;
    i_cfg_we   = 1'b0;
    i_cfg_ch   = '0;
    i_cfg_sel  = '0;
    i_cfg_data = '0;
    test_reset();
    test_config();
    test_timed();
    test_gate();
    test_gate_mid_attack();
    test_boundary();
    test_retrigger();
    test_reset_mid_decay();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
